// File: rtl/layer_fold_scheduler.sv
// Network-pass sequencer: steps the layer config bank, walks each layer's
// row/column tile folds with a start/done handshake, and runs optional pooling.
module layer_fold_scheduler #(
    parameter int NUM_LAYERS = 5,
    parameter int CFG_WAIT   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] fold_rows,
    input  logic [7:0] fold_cols,
    input  logic       pooling_en,
    input  logic [3:0] layer_index,
    output logic       layer_switch_signal,
    output logic       tile_start,
    output logic [7:0] tile_row_idx,
    output logic [7:0] tile_col_idx,
    input  logic       tile_done,
    output logic       pool_start,
    input  logic       pool_done,
    output logic [2:0] cur_layer,
    output logic       busy,
    output logic       net_done,
    output logic       cfg_err
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SWITCH     = 4'd1;
    localparam logic [3:0] S_CFG        = 4'd2;
    localparam logic [3:0] S_TILE_ISSUE = 4'd3;
    localparam logic [3:0] S_TILE_WAIT  = 4'd4;
    localparam logic [3:0] S_POOL_ISSUE = 4'd5;
    localparam logic [3:0] S_POOL_WAIT  = 4'd6;
    localparam logic [3:0] S_FINAL      = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS);
    localparam logic [7:0] CFG_LAST   = 8'(CFG_WAIT > 1 ? CFG_WAIT - 1 : 0);

    logic [3:0] state_q, state_d;
    logic [2:0] cur_layer_q, cur_layer_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] row_q, row_d;
    logic [7:0] col_q, col_d;
    logic [7:0] fold_rows_q, fold_rows_d;
    logic [7:0] fold_cols_q, fold_cols_d;
    logic       pool_en_q, pool_en_d;
    logic       cfg_err_q, cfg_err_d;
    logic       switch_q, tile_start_q, pool_start_q, busy_q, net_done_q;
    logic       last_layer;

    assign last_layer = (cur_layer_q >= LAST_LAYER);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        cur_layer_d = cur_layer_q;
        wait_d      = wait_q;
        row_d       = row_q;
        col_d       = col_q;
        fold_rows_d = fold_rows_q;
        fold_cols_d = fold_cols_q;
        pool_en_d   = pool_en_q;
        cfg_err_d   = cfg_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SWITCH;
                    cfg_err_d = 1'b0;
                end
            end
            S_SWITCH: begin
                state_d = S_CFG;
                wait_d  = 8'd0;
            end
            S_CFG: begin
                if (wait_q == CFG_LAST) begin
                    fold_rows_d = fold_rows;
                    fold_cols_d = fold_cols;
                    pool_en_d   = pooling_en;
                    row_d       = 8'd0;
                    col_d       = 8'd0;
                    // A bank that is out of step with us aborts the pass before any tile.
                    if ({1'b0, cur_layer_q} != layer_index) begin
                        cfg_err_d   = 1'b1;
                        cur_layer_d = 3'd0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_TILE_ISSUE;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_TILE_ISSUE: state_d = S_TILE_WAIT;
            S_TILE_WAIT: begin
                if (tile_done) begin
                    if (row_q != fold_rows_q) begin
                        row_d   = row_q + 8'd1;
                        state_d = S_TILE_ISSUE;
                    end else if (col_q != fold_cols_q) begin
                        row_d   = 8'd0;
                        col_d   = col_q + 8'd1;
                        state_d = S_TILE_ISSUE;
                    end else if (pool_en_q) begin
                        state_d = S_POOL_ISSUE;
                    end else begin
                        state_d = last_layer ? S_FINAL : S_SWITCH;
                    end
                end
            end
            S_POOL_ISSUE: state_d = S_POOL_WAIT;
            S_POOL_WAIT: begin
                if (pool_done) state_d = last_layer ? S_FINAL : S_SWITCH;
            end
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Layer number moves with entry into SWITCH and is dropped on entry into DONE.
        if (state_d == S_SWITCH) cur_layer_d = cur_layer_q + 3'd1;
        if (state_d == S_DONE)   cur_layer_d = 3'd0;
    end

    // NOTE: state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_layer_q  <= 3'd0;
            wait_q       <= 8'd0;
            row_q        <= 8'd0;
            col_q        <= 8'd0;
            fold_rows_q  <= 8'd0;
            fold_cols_q  <= 8'd0;
            pool_en_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            switch_q     <= 1'b0;
            tile_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            busy_q       <= 1'b0;
            net_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_layer_q  <= cur_layer_d;
            wait_q       <= wait_d;
            row_q        <= row_d;
            col_q        <= col_d;
            fold_rows_q  <= fold_rows_d;
            fold_cols_q  <= fold_cols_d;
            pool_en_q    <= pool_en_d;
            cfg_err_q    <= cfg_err_d;
            // Pulses are decoded from the next state so they align with the state itself.
            switch_q     <= (state_d == S_SWITCH) || (state_d == S_FINAL);
            tile_start_q <= (state_d == S_TILE_ISSUE);
            pool_start_q <= (state_d == S_POOL_ISSUE);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
            net_done_q   <= (state_d == S_DONE);
        end
    end

    assign layer_switch_signal = switch_q;
    assign tile_start          = tile_start_q;
    assign tile_row_idx        = row_q;
    assign tile_col_idx        = col_q;
    assign pool_start          = pool_start_q;
    assign cur_layer           = cur_layer_q;
    assign busy                = busy_q;
    assign net_done            = net_done_q;
    assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_layer_fold_scheduler.sv
// Directed bench for layer_fold_scheduler: behavioural config bank, tile/pool
// responders, and hand-computed expectations for timing, ordering and errors.
module tb_layer_fold_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] fold_rows;
    logic [7:0] fold_cols;
    logic       pooling_en;
    logic [3:0] layer_index;
    logic       layer_switch_signal;
    logic       tile_start;
    logic [7:0] tile_row_idx;
    logic [7:0] tile_col_idx;
    logic       tile_done;
    logic       pool_start;
    logic       pool_done;
    logic [2:0] cur_layer;
    logic       busy;
    logic       net_done;
    logic       cfg_err;

    layer_fold_scheduler #(.NUM_LAYERS(5), .CFG_WAIT(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .fold_rows           (fold_rows),
        .fold_cols           (fold_cols),
        .pooling_en          (pooling_en),
        .layer_index         (layer_index),
        .layer_switch_signal (layer_switch_signal),
        .tile_start          (tile_start),
        .tile_row_idx        (tile_row_idx),
        .tile_col_idx        (tile_col_idx),
        .tile_done           (tile_done),
        .pool_start          (pool_start),
        .pool_done           (pool_done),
        .cur_layer           (cur_layer),
        .busy                (busy),
        .net_done            (net_done),
        .cfg_err             (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench controls
    logic       auto_resp   = 1'b1;
    logic       man_tile    = 1'b0;
    logic       man_pool    = 1'b0;
    logic       bank_rst    = 1'b0;
    logic [3:0] bad_layer   = 4'd0;
    logic       force_en    = 1'b0;
    logic [7:0] force_rows  = 8'd0;
    logic [7:0] force_cols  = 8'd0;

    // Behavioural config bank
    logic [3:0] bank_layer;
    always @(posedge clk) begin
        if (!rst_n || bank_rst) bank_layer <= 4'd0;
        else if (layer_switch_signal) bank_layer <= (bank_layer == 4'd5) ? 4'd0 : bank_layer + 4'd1;
    end

    logic [7:0] tab_rows, tab_cols;
    logic       tab_pool;
    always_comb begin
        tab_rows = 8'd0; tab_cols = 8'd0; tab_pool = 1'b0;
        case (bank_layer)
            4'd1: begin tab_rows = 8'd13; tab_cols = 8'd27; tab_pool = 1'b1; end
            4'd2: begin tab_rows = 8'd9;  tab_cols = 8'd11; tab_pool = 1'b1; end
            4'd3: begin tab_rows = 8'd4;  tab_cols = 8'd5;  end
            4'd4: begin tab_rows = 8'd2;  tab_cols = 8'd6;  end
            4'd5: begin tab_rows = 8'd2;  tab_cols = 8'd0;  end
            default: ;
        endcase
    end
    assign fold_rows   = force_en ? force_rows : tab_rows;
    assign fold_cols   = force_en ? force_cols : tab_cols;
    assign pooling_en  = force_en ? 1'b0 : tab_pool;
    assign layer_index = (bad_layer != 4'd0 && bank_layer == bad_layer) ? 4'd3 : bank_layer;

    // Responders: tile_done 3 cycles after tile_start, pool_done 2 after pool_start
    int   tcnt = 0, pcnt = 0;
    logic resp_tile = 1'b0, resp_pool = 1'b0;
    always @(posedge clk) begin
        if (tile_start) tcnt <= 2; else if (tcnt != 0) tcnt <= tcnt - 1;
        resp_tile <= (tcnt == 1) && !tile_start;
        if (pool_start) pcnt <= 1; else if (pcnt != 0) pcnt <= pcnt - 1;
        resp_pool <= (pcnt == 1) && !pool_start;
    end
    assign tile_done = auto_resp ? resp_tile : man_tile;
    assign pool_done = auto_resp ? resp_pool : man_pool;

    // Monitor
    int          tiles_at [8];
    int          n_pool = 0, n_sw = 0, n_done = 0, last_sw_cyc = 0;
    logic [15:0] hist [$];
    initial for (int i = 0; i < 8; i++) tiles_at[i] = 0;
    always @(negedge clk) begin
        if (tile_start) begin
            tiles_at[cur_layer] = tiles_at[cur_layer] + 1;
            hist.push_back({tile_row_idx, tile_col_idx});
        end
        if (pool_start) n_pool = n_pool + 1;
        if (layer_switch_signal) begin n_sw = n_sw + 1; last_sw_cyc = cyc; end
        if (net_done) n_done = n_done + 1;
    end

    int base_t [8];
    int base_pool, base_sw, base_done, base_hist;
    task automatic snap();
        for (int i = 0; i < 8; i++) base_t[i] = tiles_at[i];
        base_pool = n_pool; base_sw = n_sw; base_done = n_done; base_hist = hist.size();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sel 0: net_done, 1: busy low, 2: tile_done
    task automatic wait_sig(input int sel, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step(1);
            case (sel)
                0:       hit = net_done;
                1:       hit = !busy;
                default: hit = tile_done;
            endcase
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, layer_switch_signal, tile_start, tile_row_idx, tile_col_idx,
                pool_start, cur_layer, busy, net_done, cfg_err};
    endfunction

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] exp_ord [6];
    int sum_nz;

    initial begin
        exp_ord = '{16'h0000, 16'h0100, 16'h0200, 16'h0001, 16'h0101, 16'h0201};
        rst_n = 1'b0; start = 1'b0;
        step(3);
        check("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Full pass with startup latency
        snap();
        pulse_start();
        check("c1_switch", {31'd0, layer_switch_signal}, 32'd1);
        check("c1_busy", {31'd0, busy}, 32'd1);
        check("c1_layer", {29'd0, cur_layer}, 32'd1);
        step(2);
        check("c3_no_tile", {31'd0, tile_start}, 32'd0);
        step(1);
        check("c4_tile_start", {31'd0, tile_start}, 32'd1);
        check("c4_idx", {16'd0, tile_row_idx, tile_col_idx}, 32'h0000);
        wait_sig(2, 10, "wait_tile_done");
        step(1);
        check("next_tile_start", {31'd0, tile_start}, 32'd1);
        check("next_tile_idx", {16'd0, tile_row_idx, tile_col_idx}, 32'h0100);
        pulse_start();  // ignored while busy
        wait_sig(0, 5000, "wait_net_done_full");
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_layer", {29'd0, cur_layer}, 32'd0);
        check("final_gap", cyc - last_sw_cyc, 32'd1);
        step(1);
        check("tiles_l1", tiles_at[1] - base_t[1], 32'd392);
        check("tiles_l2", tiles_at[2] - base_t[2], 32'd120);
        check("tiles_l3", tiles_at[3] - base_t[3], 32'd30);
        check("tiles_l4", tiles_at[4] - base_t[4], 32'd21);
        check("tiles_l5", tiles_at[5] - base_t[5], 32'd3);
        check("pool_pulses", n_pool - base_pool, 32'd2);
        check("switch_pulses", n_sw - base_sw, 32'd6);
        check("net_done_pulses", n_done - base_done, 32'd1);
        check("full_cfg_err", {31'd0, cfg_err}, 32'd0);

        // Index order with folds 2/1
        force_en = 1'b1; force_rows = 8'd2; force_cols = 8'd1;
        step(1);
        snap();
        pulse_start();
        wait_sig(0, 1000, "wait_net_done_order");
        step(1);
        for (int i = 0; i < 6; i++)
            check($sformatf("order_%0d", i), {16'd0, hist[base_hist + i]}, {16'd0, exp_ord[i]});
        check("order_l1_tiles", tiles_at[1] - base_t[1], 32'd6);
        check("order_total", hist.size() - base_hist, 32'd30);

        // Error path: bank reports index 3 at the layer 2 latch
        force_rows = 8'd0; force_cols = 8'd0; bad_layer = 4'd2;
        snap();
        pulse_start();
        wait_sig(1, 100, "wait_err_idle");
        check("err_flag", {31'd0, cfg_err}, 32'd1);
        check("err_layer", {29'd0, cur_layer}, 32'd0);
        step(3);
        check("err_sticky", {31'd0, cfg_err}, 32'd1);
        check("err_no_l2_tile", tiles_at[2] - base_t[2], 32'd0);
        check("err_no_net_done", n_done - base_done, 32'd0);

        // Recovery with folds 0/0: start clears the error, one tile per layer at (0,0)
        bad_layer = 4'd0; bank_rst = 1'b1; step(1); bank_rst = 1'b0;
        snap();
        pulse_start();
        check("err_cleared", {31'd0, cfg_err}, 32'd0);
        wait_sig(0, 500, "wait_net_done_00");
        step(1);
        check("tiles_00", hist.size() - base_hist, 32'd5);
        sum_nz = 0;
        for (int i = base_hist; i < hist.size(); i++) if (hist[i] != 16'h0000) sum_nz++;
        check("idx_00", sum_nz, 32'd0);

        // Spurious handshakes under manual control, folds 1/0
        auto_resp = 1'b0; force_rows = 8'd1;
        man_tile = 1'b1; step(1); man_tile = 1'b0;  // tile_done in IDLE
        pulse_start();
        step(3);
        check("m_tile_start0", {31'd0, tile_start}, 32'd1);
        man_tile = 1'b1;  // sampled while in TILE_ISSUE
        step(1);
        man_tile = 1'b0;
        check("m_issue_done_ignored", {16'd0, tile_row_idx, tile_col_idx}, 32'h0000);
        man_pool = 1'b1;  // pool_done in TILE_WAIT, pooling disabled
        step(1);
        man_pool = 1'b0;
        check("m_pool_done_ignored", {30'd0, tile_start, pool_start}, 32'd0);
        man_tile = 1'b1;
        step(1);
        man_tile = 1'b0;
        check("m_tile_start1", {31'd0, tile_start}, 32'd1);
        check("m_idx1", {16'd0, tile_row_idx, tile_col_idx}, 32'h0100);
        step(1);
        man_tile = 1'b1; man_pool = 1'b1;
        step(1);
        man_tile = 1'b0; man_pool = 1'b0;
        check("m_no_pool", {31'd0, pool_start}, 32'd0);
        check("m_switch_l2", {28'd0, layer_switch_signal, cur_layer}, 32'h0A);
        step(3);
        check("m_l2_tile", {31'd0, tile_start}, 32'd1);

        // Reset during layer 2 tiling
        rst_n = 1'b0;
        step(1);
        check("midreset_outs", all_outs(), 32'd0);
        step(2);
        rst_n = 1'b1;
        auto_resp = 1'b1;
        step(1);
        pulse_start();
        check("restart_layer", {28'd0, layer_switch_signal, cur_layer}, 32'h09);
        wait_sig(0, 500, "wait_net_done_restart");
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_fold_scheduler.md
# layer_fold_scheduler

Top-level sequencer for the systolic-array CNN accelerator. It steps the layer configuration bank through all network layers by pulsing `layer_switch_signal`, then latches each layer's fold counts. For each layer it walks the SA tile loop (`FOLD_ROWS`+1 × `FOLD_COLS`+1) with a start/done handshake, runs pooling when enabled, and returns the bank to its idle layer after the final layer.

## Interface
Parameters:
- `NUM_LAYERS`, default 5: number of layers in the network; the bank's last layer index.
- `CFG_WAIT`, default 2: cycles between the `layer_switch_signal` pulse and the config latch.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `start`, in, 1: begin one full network pass; sampled only in IDLE.
- `fold_rows`, in, 8: from bank `FOLD_ROWS`; last row-fold index.
- `fold_cols`, in, 8: from bank `FOLD_COLS`; last column-fold index.
- `pooling_en`, in, 1: from bank.
- `layer_index`, in, 4: from bank; checked against `cur_layer`.
- `layer_switch_signal`, out, 1: one-cycle pulse to the bank.
- `tile_start`, out, 1: one-cycle pulse; the SA computes one tile.
- `tile_row_idx`, out, 8: row-fold index of the current tile.
- `tile_col_idx`, out, 8: column-fold index of the current tile.
- `tile_done`, in, 1: SA finished the current tile.
- `pool_start`, out, 1: one-cycle pulse; pool the whole layer.
- `pool_done`, in, 1: pooling finished.
- `cur_layer`, out, 3: current layer, 1..`NUM_LAYERS` while busy; 0 in idle.
- `busy`, out, 1: high from the first switch pulse until `net_done` or error.
- `net_done`, out, 1: one-cycle pulse at the end of a pass.
- `cfg_err`, out, 1: sticky error; set on a layer-index mismatch, cleared by the next accepted `start`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Reset clears the FSM to IDLE and clears the counters and latched config.
- States and transitions:
  - IDLE: on `start`, go to SWITCH; clear `cfg_err`.
  - SWITCH: pulse `layer_switch_signal`; `cur_layer` increments; go to CFG.
  - CFG: wait `CFG_WAIT` cycles, then latch `fold_rows`, `fold_cols`, `pooling_en`, `layer_index`. Clear the row and column counters. Go to TILE_ISSUE.
  - Index check at latch: if zero-extended `cur_layer` ≠ `layer_index`, set `cfg_err`, drop `busy`, clear `cur_layer`, go to IDLE. No `tile_start` is issued.
  - TILE_ISSUE: pulse `tile_start` with the current indices; go to TILE_WAIT.
  - TILE_WAIT: on `tile_done`, advance the counters. Row is inner: row++ until row = `fold_rows`, then row←0 and col++.
  - After the last tile (row = `fold_rows`, col = `fold_cols`):
    - `pooling_en` = 1: go to POOL_ISSUE.
    - else, `cur_layer` < `NUM_LAYERS`: go to SWITCH.
    - else: go to FINAL.
  - Otherwise (not the last tile): go to TILE_ISSUE.
  - POOL_ISSUE: pulse `pool_start`; go to POOL_WAIT.
  - POOL_WAIT: on `pool_done`, go to SWITCH (or FINAL if this is the last layer).
  - FINAL: pulse `layer_switch_signal`, which returns the bank flag to 0. Go to DONE.
  - DONE: pulse `net_done`; `busy`←0, `cur_layer`←0; go to IDLE.
- Handshake inputs are used only in their own state:
  - `tile_done` is honoured only in TILE_WAIT and ignored elsewhere.
  - `pool_done` is honoured only in POOL_WAIT and ignored elsewhere.
  - `start` is ignored unless in IDLE.
- Counter arithmetic is 8-bit with compare-for-equality before increment, so there is no wrap. `fold_rows` = 255 gives 256 row tiles.
- Total tiles per layer = (`fold_rows`+1)·(`fold_cols`+1).
- Degenerate 0/0 folds give exactly one tile, at (0,0).
- Reset mid-operation: outputs drop at the first clock edge with `rst_n` = 0. No FINAL switch is issued, because the bank is reset by the same `rst_n`.

## Timing
- `start` high in cycle 0 (IDLE):
  - cycle 1: `layer_switch_signal` = 1, `busy` = 1, `cur_layer` = 1.
  - cycles 2–3: CFG; bank config becomes valid in cycle 3; latch at the end of cycle 3.
  - cycle 4: `tile_start` = 1 with indices (0,0).
- `tile_done` in cycle N:
  - next `tile_start` in cycle N+1 with the advanced indices;
  - if it was the last tile: `pool_start` or the next `layer_switch_signal` in N+1.
- `pool_done` in cycle M: `layer_switch_signal` in M+1.
- Last layer's final done in cycle N: FINAL pulse in N+1; `net_done` = 1 and `busy` = 0 in N+2.
- Minimum tile period: 2 cycles (ISSUE + WAIT with `tile_done` in the WAIT cycle).
- Two switch pulses are always at least 4 cycles apart, so the bank's `start_cal_folding_flag` never blocks an increment.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles during layer 2 tiling → at the next edge all outputs are 0; `start` after release restarts at `cur_layer` = 1.
- Full pass with a behavioural config bank and a 3-cycle `tile_done` responder → tile counts per layer are 392, 120, 30, 21 and 3. Also expect exactly 2 `pool_start` pulses (layers 1 and 2), 6 `layer_switch_signal` pulses, one `net_done`, and `cfg_err` = 0.
- Startup latency: `start` in cycle 0 → `layer_switch_signal` in cycle 1, `tile_start` in cycle 4 at (0,0). The next `tile_start` comes 1 cycle after each `tile_done`.
- Index order: `fold_rows` = 2, `fold_cols` = 1 → tiles at (0,0), (1,0), (2,0), (0,1), (1,1), (2,1), then the next phase.
- Error path: bank reports `layer_index` = 3 at the layer 2 latch → `cfg_err` = 1, `busy` = 0, `cur_layer` = 0 and no `tile_start`. A following `start` clears `cfg_err`.
- Spurious inputs:
  - `tile_done` during TILE_ISSUE or IDLE → no index advance.
  - `start` while busy → ignored.
  - `pool_done` while `pooling_en` = 0 → no effect.
  - Folds 0/0 → exactly one tile at (0,0).
